// File: rtl/trdy_burst_ctrl.sv
// PCI target-ready burst controller: sequences TRDY# over multi-phase bursts with
// initial latency, storage-driven wait states, data-phase counting and STOP# disconnect.
module trdy_burst_ctrl #(
    parameter int WAIT_STATES = 0,
    parameter int MAX_BURST   = 4,
    parameter int CNT_W       = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             Frame,
    input  logic             Irdy,
    input  logic             devsel,
    input  logic             storageReady,
    output logic             Trdy,
    output logic             Stop,
    output logic             dataStrobe,
    output logic [CNT_W-1:0] dataPhaseCount,
    output logic [2:0]       o_dbg_state
);

    localparam int WAIT_W = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LOAD     = WAIT_W'(WAIT_STATES);
    localparam logic [CNT_W-1:0]  BURST_LIMIT   = CNT_W'(MAX_BURST);
    localparam bit                BURST_LIMITED = (MAX_BURST != 0);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_WAIT = 3'd1;
    localparam logic [2:0] S_DATA = 3'd2;
    localparam logic [2:0] S_DISC = 3'd3;
    localparam logic [2:0] S_TURN = 3'd4;

    logic [2:0]        r_state;
    logic [WAIT_W-1:0] r_wait;
    logic [CNT_W-1:0]  r_count;
    logic              r_trdy;
    logic              r_stop;

    logic [2:0]        w_next_state;
    logic [WAIT_W-1:0] w_next_wait;
    logic [CNT_W-1:0]  w_next_count;
    logic [CNT_W-1:0]  w_count_inc;
    logic              w_claim;
    logic              w_abort;
    logic              w_complete;

    assign w_claim     = !devsel && !Frame;
    assign w_abort     = devsel;
    assign w_complete  = (r_state == S_DATA) && !Irdy;
    assign w_count_inc = r_count + CNT_W'(1);

    // A completing phase is counted even if DEVSEL# drops in the same cycle,
    // since the strobe was already presented to storage.
    always_comb begin
        w_next_state = r_state;
        w_next_wait  = r_wait;
        w_next_count = r_count;
        case (r_state)
            S_IDLE: begin
                if (w_claim) begin
                    w_next_state = S_WAIT;
                    w_next_wait  = WAIT_LOAD;
                    w_next_count = '0;
                end
            end
            S_WAIT: begin
                if (w_abort) begin
                    w_next_state = S_IDLE;
                end else if (r_wait != '0) begin
                    w_next_wait = r_wait - WAIT_W'(1);
                end else if (storageReady) begin
                    w_next_state = S_DATA;
                end
            end
            S_DATA: begin
                if (w_complete) begin
                    w_next_count = w_count_inc;
                end
                if (w_abort) begin
                    w_next_state = S_IDLE;
                end else if (w_complete) begin
                    if (Frame) begin
                        w_next_state = S_TURN;
                    end else if (BURST_LIMITED && (w_count_inc == BURST_LIMIT)) begin
                        w_next_state = S_DISC;
                    end else if (!storageReady) begin
                        w_next_state = S_WAIT;
                        w_next_wait  = '0;
                    end
                end
            end
            S_DISC: begin
                if (w_abort) begin
                    w_next_state = S_IDLE;
                end else if (Frame) begin
                    w_next_state = S_TURN;
                end
            end
            S_TURN: begin
                w_next_state = S_IDLE;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // Outputs are registered from the next state so they change on the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_wait  <= '0;
            r_count <= '0;
            r_trdy  <= 1'b1;
            r_stop  <= 1'b1;
        end else begin
            r_state <= w_next_state;
            r_wait  <= w_next_wait;
            r_count <= w_next_count;
            r_trdy  <= (w_next_state != S_DATA);
            r_stop  <= (w_next_state != S_DISC);
        end
    end

    assign Trdy           = r_trdy;
    assign Stop           = r_stop;
    assign dataStrobe     = !r_trdy && !Irdy;
    assign dataPhaseCount = r_count;
    assign o_dbg_state    = r_state;

endmodule
